// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: pipeline slot record, bubble constant and
// memory-request state encoding.
package hazard_pkg;

    localparam int HZ_REG_W = 5;
    localparam logic [HZ_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] wsel;
        logic                regwen;
        logic                memren;
        logic                memwen;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } req_state_t;

    // Destination seen by the hazard unit; writes to $0 never create a dependency.
    function automatic logic [HZ_REG_W-1:0] slot_dest(input slot_t s);
        return (s.valid && s.regwen && (s.wsel != REG_ZERO)) ? s.wsel : REG_ZERO;
    endfunction

    function automatic logic slot_has_mem(input slot_t s);
        return s.valid && (s.memren || s.memwen);
    endfunction

endpackage

// File: rtl/sb_slot.sv
// One tracked pipeline slot: flush beats load, otherwise the record holds.
module sb_slot
    import hazard_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  flush,
    input  slot_t d,
    output slot_t q
);

    slot_t slot_q;
    slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d = BUBBLE;
        end else if (load) begin
            slot_d = d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_q <= BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer side of the hazard interface: tracks EX/MEM/WB destinations and MEM-stage
// memory requests. Optional counters are enabled with HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W  = HZ_REG_W,
    parameter int STAT_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwen,
    input  logic              id_memren,
    input  logic              id_memwen,
    input  logic              execute_en,
    input  logic              memory_en,
    input  logic              ddeassert,
    input  logic              edeassert,
    input  logic              mdeassert,
    input  logic              dhit,
`ifdef HAZARD_SCOREBOARD_STATS_EN
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt,
`endif
    output logic [REG_W-1:0]  read1,
    output logic [REG_W-1:0]  read2,
    output logic [REG_W-1:0]  write1,
    output logic [REG_W-1:0]  write2,
    output logic [REG_W-1:0]  write3,
    output logic              dW,
    output logic              memREN,
    output logic              memWEN
);

    slot_t      id_rec;
    slot_t      ex_q;
    slot_t      mem_q;
    slot_t      wb_q;
    slot_t      mem_in;
    logic       ex_flush;
    logic       mem_reload;
    req_state_t req_state_q;
    req_state_t req_state_d;

    assign id_rec = '{valid: id_valid, wsel: id_wsel, regwen: id_regwen,
                      memren: id_memren, memwen: id_memwen};

    assign ex_flush = edeassert || (execute_en && (ddeassert || !id_valid));

    sb_slot u_ex_slot (
        .CLK   (CLK),
        .RST   (RST),
        .load  (execute_en),
        .flush (ex_flush),
        .d     (id_rec),
        .q     (ex_q)
    );

    sb_slot u_mem_slot (
        .CLK   (CLK),
        .RST   (RST),
        .load  (memory_en),
        .flush (mdeassert),
        .d     (ex_q),
        .q     (mem_q)
    );

    // WB never holds: without an advance it drains to a bubble.
    sb_slot u_wb_slot (
        .CLK   (CLK),
        .RST   (RST),
        .load  (memory_en),
        .flush (!memory_en),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign mem_reload = memory_en || mdeassert;
    assign mem_in     = mdeassert ? BUBBLE : ex_q;

    always_comb begin
        req_state_d = req_state_q;
        if (mem_reload) begin
            req_state_d = slot_has_mem(mem_in) ? REQ : IDLE;
        end else if ((req_state_q == REQ) && dhit) begin
            req_state_d = DONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_state_q <= IDLE;
        end else begin
            req_state_q <= req_state_d;
        end
    end

    assign read1  = id_valid ? id_rs : '0;
    assign read2  = id_valid ? id_rt : '0;
    assign write1 = slot_dest(ex_q);
    assign write2 = slot_dest(mem_q);
    assign write3 = slot_dest(wb_q);
    assign dW     = wb_q.valid && wb_q.regwen;

    // A record claiming both load and store is treated as a load.
    assign memREN = (req_state_q == REQ) && mem_q.memren;
    assign memWEN = (req_state_q == REQ) && mem_q.memwen && !mem_q.memren;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(mem_q.valid && mem_q.memren && mem_q.memwen));
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] stall_cnt_d;
    logic [STAT_W-1:0] bubble_cnt_q;
    logic [STAT_W-1:0] bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!execute_en && id_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((edeassert || (execute_en && ddeassert)) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against a behavioural pipeline model.
module tb_hazard_scoreboard;

    localparam int REG_W  = 5;
    localparam int STAT_W = 4;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic id_valid = 0, id_regwen = 0, id_memren = 0, id_memwen = 0;
    logic [REG_W-1:0] id_rs = 0, id_rt = 0, id_wsel = 0;
    logic execute_en = 0, memory_en = 0, ddeassert = 0, edeassert = 0, mdeassert = 0, dhit = 0;
    logic [REG_W-1:0] read1, read2, write1, write2, write3;
    logic dW, memREN, memWEN;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt, bubble_cnt;
    int stall_m, bubble_m;
`endif

    hazard_scoreboard #(.REG_W(REG_W), .STAT_W(STAT_W)) dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
        .id_regwen(id_regwen), .id_memren(id_memren), .id_memwen(id_memwen),
        .execute_en(execute_en), .memory_en(memory_en),
        .ddeassert(ddeassert), .edeassert(edeassert), .mdeassert(mdeassert), .dhit(dhit),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .read1(read1), .read2(read2), .write1(write1), .write2(write2), .write3(write3),
        .dW(dW), .memREN(memREN), .memWEN(memWEN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit v;
        int w;
        bit rw;
        bit rd;
        bit wr;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;
    bit   m_served;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic rec_t bubble();
        rec_t r;
        r = '{v: 0, w: 0, rw: 0, rd: 0, wr: 0};
        return r;
    endfunction

    function automatic int dest(input rec_t r);
        return (r.v && r.rw && r.w != 0) ? r.w : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ex = bubble();
        m_mem = bubble();
        m_wb = bubble();
        m_served = 0;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        stall_m = 0;
        bubble_m = 0;
`endif
    endtask

    task automatic check_outputs();
        bit pend;
        pend = m_mem.v && !m_served;
        check("write1", 32'(write1), dest(m_ex));
        check("write2", 32'(write2), dest(m_mem));
        check("write3", 32'(write3), dest(m_wb));
        check("dW", 32'(dW), 32'(m_wb.v && m_wb.rw));
        check("memREN", 32'(memREN), 32'(pend && m_mem.rd));
        check("memWEN", 32'(memWEN), 32'(pend && m_mem.wr && !m_mem.rd));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("stall_cnt", 32'(stall_cnt), stall_m);
        check("bubble_cnt", 32'(bubble_cnt), bubble_m);
`endif
    endtask

    // One clock: inputs are already applied; model advances with the same pre-edge values.
    task automatic step();
        rec_t idr, n_ex, n_mem, n_wb;
        bit   pend_pre;
        #1;
        check("read1", 32'(read1), id_valid ? 32'(id_rs) : 32'd0);
        check("read2", 32'(read2), id_valid ? 32'(id_rt) : 32'd0);
        @(posedge CLK);
        idr = '{v: id_valid, w: int'(id_wsel), rw: id_regwen, rd: id_memren, wr: id_memwen};
        pend_pre = m_mem.v && (m_mem.rd || m_mem.wr) && !m_served;
        n_wb  = memory_en ? m_mem : bubble();
        n_mem = mdeassert ? bubble() : (memory_en ? m_ex : m_mem);
        if (edeassert) n_ex = bubble();
        else if (execute_en) n_ex = (ddeassert || !id_valid) ? bubble() : idr;
        else n_ex = m_ex;
        if (mdeassert || memory_en) m_served = 0;
        else if (pend_pre && dhit) m_served = 1;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        if (!execute_en && id_valid && stall_m < STAT_MAX) stall_m++;
        if ((edeassert || (execute_en && ddeassert)) && bubble_m < STAT_MAX) bubble_m++;
`endif
        m_ex = n_ex;
        m_mem = n_mem;
        m_wb = n_wb;
        #1;
        check_outputs();
    endtask

    task automatic set_id(input bit v, input int w, input bit rw, input bit rd, input bit wr);
        id_valid = v;
        id_wsel = REG_W'(w);
        id_regwen = rw;
        id_memren = rd;
        id_memwen = wr;
        id_rs = REG_W'($urandom);
        id_rt = REG_W'($urandom);
    endtask

    task automatic set_ctl(input bit ex, input bit mem, input bit dd, input bit ed, input bit md, input bit hit);
        execute_en = ex;
        memory_en = mem;
        ddeassert = dd;
        edeassert = ed;
        mdeassert = md;
        dhit = hit;
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_write1", 32'(write1), 0);
        check("rst_memREN", 32'(memREN), 0);
        @(posedge CLK);
        #1;
        RST = 0;

`ifdef HAZARD_SCOREBOARD_STATS_EN
        set_id(1, 3, 1, 0, 0);
        set_ctl(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        check("stall_four", 32'(stall_cnt), 4);
`endif

        // Flow of a writer to r8.
        set_id(1, 8, 1, 0, 0);
        set_ctl(1, 1, 0, 0, 0, 0);
        step();
        check("flow_w1", 32'(write1), 8);
        set_id(0, 0, 0, 0, 0);
        step();
        check("flow_w2", 32'(write2), 8);
        step();
        check("flow_w3", 32'(write3), 8);
        check("flow_dW", 32'(dW), 1);
        set_id(1, 0, 1, 0, 0);
        step();
        check("zero_w1", 32'(write1), 0);
        set_id(0, 0, 0, 0, 0);
        repeat (3) step();

        // Load to r5 stalled in MEM waiting for dhit.
        set_id(1, 5, 1, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0);
        step();
        check("load_req0", 32'(memREN), 1);
        set_ctl(0, 0, 0, 0, 0, 0);
        step();
        check("load_req1", 32'(memREN), 1);
        step();
        check("load_req2", 32'(memREN), 1);
        dhit = 1;
        step();
        check("load_drop", 32'(memREN), 0);
        dhit = 0;
        step();
        check("load_done", 32'(memREN), 0);
        check("load_w2", 32'(write2), 5);
        set_ctl(0, 1, 0, 0, 0, 0);
        step();
        check("load_w3", 32'(write3), 5);

        // Squash EX while MEM takes the old EX record.
        set_id(1, 9, 1, 0, 0);
        set_ctl(1, 1, 0, 0, 0, 0);
        step();
        set_id(1, 10, 1, 0, 0);
        set_ctl(1, 1, 0, 1, 0, 0);
        step();
        check("squash_w1", 32'(write1), 0);
        check("squash_w2", 32'(write2), 9);

        // Decode squash and invalid decode.
        set_id(1, 11, 1, 0, 0);
        set_ctl(1, 1, 1, 0, 0, 0);
        step();
        check("dsquash_w1", 32'(write1), 0);
        set_id(0, 12, 1, 0, 0);
        set_ctl(1, 1, 0, 0, 0, 0);
        step();
        check("inv_read1", 32'(read1), 0);
        check("inv_read2", 32'(read2), 0);

        // Fill all stages, leave a load pending in MEM, then reset asynchronously.
        set_id(1, 7, 1, 0, 0);
        step();
        set_id(1, 6, 1, 1, 0);
        step();
        set_id(1, 4, 1, 0, 0);
        step();
        check("pre_rst_req", 32'(memREN), 1);
        check("pre_rst_w3", 32'(write3), 7);
        RST = 1;
        #1;
        model_reset();
        check("arst_w1", 32'(write1), 0);
        check("arst_w2", 32'(write2), 0);
        check("arst_w3", 32'(write3), 0);
        check("arst_dW", 32'(dW), 0);
        check("arst_memREN", 32'(memREN), 0);
        check("arst_memWEN", 32'(memWEN), 0);
        @(posedge CLK);
        #1;
        RST = 0;
        set_ctl(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int op;
            op = int'($urandom_range(0, 5));
            set_id($urandom_range(0, 7) != 0, int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                   op == 0, op == 1);
            set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of the hazard-unit interface: tracks destination registers and memory intent of instructions in flight in EX, MEM and WB.
- Drives read1/read2, write1..write3, dW, memREN and memWEN toward the hazard unit.
- Consumes the hazard unit's stage enables and deasserts, so the tracked state advances, holds and squashes in lock-step with the datapath latches.
- Sits beside the ID/EX, EX/MEM and MEM/WB latches in the pipelined datapath.

Parameters:
- REG_W, 5, register-index width.
- STAT_W, 32, width of optional statistics counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs  in  REG_W  decode source 1.
- id_rt  in  REG_W  decode source 2.
- id_wsel  in  REG_W  decode destination.
- id_regwen  in  1  decode instruction writes the register file.
- id_memren  in  1  decode instruction is a load.
- id_memwen  in  1  decode instruction is a store.
- execute_en  in  1  ID->EX advance.
- memory_en  in  1  EX->MEM and MEM->WB advance.
- ddeassert  in  1  squash decode instruction on entry to EX.
- edeassert  in  1  flush EX slot.
- mdeassert  in  1  flush MEM slot.
- dhit  in  1  data memory completed the MEM-stage request.
- read1  out  REG_W  id_rs if id_valid, else 0.
- read2  out  REG_W  id_rt if id_valid, else 0.
- write1  out  REG_W  EX destination, 0 if none.
- write2  out  REG_W  MEM destination, 0 if none.
- write3  out  REG_W  WB destination, 0 if none.
- dW  out  1  WB slot valid and writing.
- memREN  out  1  MEM-stage load request pending.
- memWEN  out  1  MEM-stage store request pending.

Behaviour:
- Slot record {valid, wsel, regwen, memren, memwen} held for EX, MEM and WB. A bubble is an all-zero record.
- Reset: all slots are bubbles and the request FSM is IDLE. All registered outputs read 0 while RST is high. read1/read2 stay combinational.
- writeN = (slot.valid && slot.regwen && slot.wsel != 0) ? slot.wsel : 0. A write to $0 is never reported.
- EX next state, in priority order:
  - edeassert -> bubble.
  - else execute_en -> bubble if ddeassert or !id_valid, otherwise the decode record.
  - else hold.
- MEM next state, in priority order:
  - mdeassert -> bubble.
  - else memory_en -> EX slot.
  - else hold.
- WB next state: memory_en -> MEM slot; else bubble. WB commits every cycle and never holds.
- Simultaneous events: deassert beats enable in the same stage. Each stage evaluates on pre-edge values, so EX may flush while MEM loads the old EX record.
- Request FSM, tracking the MEM slot:
  - IDLE: no memory op in MEM.
  - REQ: MEM slot valid with memren or memwen.
  - DONE: dhit has been seen for the current MEM record.
- memREN = (state==REQ) && MEM.memren. memWEN = (state==REQ) && MEM.memwen.
- FSM transitions:
  - REQ + dhit -> DONE; requests drop the next cycle.
  - Any MEM reload (memory_en or mdeassert) re-evaluates to REQ or IDLE from the incoming record.
  - DONE holds while MEM holds.
  - dhit in IDLE or DONE is ignored.
- Latency: one cycle from an enable to the updated write/mem outputs.
- Reset asserted mid-request drops memREN/memWEN asynchronously.
- memren and memwen both set in one record is illegal. Flag it with an assertion; memREN takes precedence.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- When defined: adds outputs stall_cnt and bubble_cnt, each STAT_W bits.
  - stall_cnt increments each cycle execute_en=0 with id_valid=1.
  - bubble_cnt increments each cycle a bubble is inserted into EX by ddeassert or edeassert.
  - Both saturate and reset to 0.
- When not defined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the slot_t packed struct;
  - the BUBBLE constant;
  - the req_state_t enum {IDLE, REQ, DONE};
  - REG_ZERO = 0.
- One natural sub-module, sb_slot: a single slot register with load, flush and hold controls, instantiated three times.

Test Plan:
- Reset: RST=1 with EX, MEM and WB previously holding valid writers -> write1/2/3, dW, memREN and memWEN all 0 immediately, before the next clock edge.
- Flow: id_wsel=8, regwen=1, enables=1 for 3 cycles -> write1=8 at cycle 1, write2=8 at cycle 2, write3=8 with dW=1 at cycle 3. id_wsel=0 -> writes stay 0.
- Load: load to reg 5 reaches MEM with memory_en=0, dhit arriving 3 cycles later -> memREN=1 for 3 cycles then 0, DONE holds; memory_en=1 -> write3=5.
- Squash: edeassert=1 together with execute_en=1 -> EX becomes a bubble (write1=0) while MEM receives the old EX record.
- Decode: ddeassert=1 -> EX gets a bubble. id_valid=0 -> read1=read2=0.
- Stats (macro defined): 4 cycles with execute_en=0 and id_valid=1 -> stall_cnt=4. Saturation at 2^STAT_W-1 is checked with STAT_W=4.
